// File: rtl/uart_imem_loader_if.sv
// Bus bundle between the boot loader, the UART receiver and the instruction memory.
// master: the loader side; slave: the UART/imem/system side.
interface uart_imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              uart_rx_valid;
    logic [7:0]        uart_rx_data;
    logic              uart_rx_break;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              write_done;
    logic              overflow;
    logic              cpu_rst_n;

    modport master (
        input  uart_rx_valid, uart_rx_data, uart_rx_break,
        output imem_we, imem_addr, imem_wdata, write_done, overflow, cpu_rst_n
    );

    modport slave (
        output uart_rx_valid, uart_rx_data, uart_rx_break,
        input  imem_we, imem_addr, imem_wdata, write_done, overflow, cpu_rst_n
    );
endinterface

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes little-endian into words, writes them to imem, and holds the
// core in reset until the end marker (or a full memory). Optional macro: BOOT_TIMEOUT_EN.
module uart_imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] END_WORD  = 32'hFFFF_FFFF,
    parameter int unsigned END_COUNT = 2,
    parameter int unsigned TIMEOUT   = 50000
) (
    input logic               clk,
    input logic               resetn,
    uart_imem_loader_if.master bus
);
    typedef enum logic [1:0] {StLoad, StWrite, StDone} state_e;

    state_e            state_q;
    logic [1:0]        byte_idx_q;
    logic [3:0]        end_cnt_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              done_q;
    logic              ovf_q;

    logic [3:0]        end_cnt_d;
    logic              end_hit;
    logic              addr_last;
    logic              tmo_fire;

    always_comb begin
        end_cnt_d = (wdata_q == END_WORD) ? end_cnt_q + 4'd1 : 4'd0;
        end_hit   = (end_cnt_d == 4'(END_COUNT));
        addr_last = &addr_q;
    end

`ifdef BOOT_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    logic [TmoW-1:0] tmo_q;

    assign tmo_fire = (state_q == StLoad) && (byte_idx_q != 2'd0) && !bus.uart_rx_valid &&
                      (tmo_q == TmoW'(TIMEOUT - 1));

    // Only counts while a partial word is pending; any byte, break or expiry restarts it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmo_q <= '0;
        end else if (state_q != StLoad || byte_idx_q == 2'd0 || bus.uart_rx_valid ||
                     bus.uart_rx_break || tmo_fire) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StLoad;
            byte_idx_q <= 2'd0;
            end_cnt_q  <= 4'd0;
            wdata_q    <= 32'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                StLoad: begin
                    // Break wins over a coincident byte, which is dropped.
                    if (bus.uart_rx_break || tmo_fire) begin
                        byte_idx_q <= 2'd0;
                        wdata_q    <= 32'd0;
                    end else if (bus.uart_rx_valid) begin
                        wdata_q[{byte_idx_q, 3'b000} +: 8] <= bus.uart_rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_q <= StWrite;
                            we_q    <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    end_cnt_q <= end_cnt_d;
                    if (end_hit || addr_last) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        ovf_q   <= !end_hit;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        state_q <= StLoad;
                    end
                end
                StDone: begin
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.write_done = done_q;
    assign bus.overflow   = ovf_q;
    assign bus.cpu_rst_n  = done_q;
endmodule
